// File: rtl/video_pkg.sv
// Shared constants and FSM state type for the video-in frame-buffer write path.
package video_pkg;

    localparam int unsigned NBPACK      = 16;
    localparam int unsigned p_WIDTH     = 640;
    localparam int unsigned p_HEIGHT    = 480;
    localparam int unsigned FRAME_WORDS = p_WIDTH * p_HEIGHT / 4;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        NEXT,
        DONE
    } state_e;

endpackage

// File: rtl/pixel_packer.sv
// Big-endian 4x8-bit -> 32-bit packing into a one-burst buffer of NBPACK words.
module pixel_packer
    import video_pkg::*;
#(
    parameter int unsigned NBPACK = video_pkg::NBPACK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  pixel,
    input  logic        pop_word,
    output logic        last_byte,
    output logic        last_word,
    output logic [31:0] word
);

    localparam int unsigned WordW  = (NBPACK > 1) ? $clog2(NBPACK) : 1;
    localparam int unsigned ByteW  = WordW + 2;
    localparam int unsigned NBytes = 4 * NBPACK;

    logic [7:0]       pack_q [NBytes];
    logic [ByteW-1:0] byte_idx_q;
    logic [WordW-1:0] burst_idx_q;
    logic [ByteW-1:0] rd_base;

    assign last_byte = (byte_idx_q == ByteW'(NBytes - 1));
    assign last_word = (burst_idx_q == WordW'(NBPACK - 1));
    assign rd_base   = {burst_idx_q, 2'b00};

    // Earliest-popped pixel lands in the most significant byte.
    assign word = {pack_q[rd_base],
                   pack_q[rd_base | ByteW'(1)],
                   pack_q[rd_base | ByteW'(2)],
                   pack_q[rd_base | ByteW'(3)]};

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q  <= '0;
            burst_idx_q <= '0;
        end else begin
            if (push) begin
                pack_q[byte_idx_q] <= pixel;
                byte_idx_q         <= last_byte ? '0 : byte_idx_q + ByteW'(1);
            end
            if (pop_word) begin
                burst_idx_q <= last_word ? '0 : burst_idx_q + WordW'(1);
            end
        end
    end

endmodule

// File: rtl/video_in_write.sv
// Video-in write path: pops FIFO pixels, packs bursts and writes them to RAM as a Wishbone master.
// Define VIDEO_IN_WRITE_FRAME_CNT_EN to add the frame_count output.
module video_in_write
    import video_pkg::*;
#(
    parameter int unsigned NBPACK   = video_pkg::NBPACK,
    parameter int unsigned p_WIDTH  = video_pkg::p_WIDTH,
    parameter int unsigned p_HEIGHT = video_pkg::p_HEIGHT
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] wb_reg_data,
    input  logic [31:0] wb_reg_ctr,
    output logic        interrupt,
    output logic [31:0] p_wb_DAT_O,
    input  logic        p_wb_ACK_I,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic        p_wb_WE_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic        empty,
    output logic        r_e,
`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
    output logic [15:0] frame_count,
`endif
    input  logic [7:0]  pixel_in
);

    localparam int unsigned FrameWords = p_WIDTH * p_HEIGHT / 4;

    state_e      state_q;
    logic        ctr0_q;
    logic [31:0] base_q;
    logic [16:0] word_cnt_q;
    logic [1:0]  int_cnt_q;
    logic        stb_q;
    logic        cyc_q;
    logic        interrupt_q;
    logic        arm;
    logic        pop;
    logic        ack;
    logic        last_byte;
    logic        last_word;
    logic [31:0] word;
    logic        unused_bits;

    assign unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};

    assign arm = wb_reg_ctr[0] & ~ctr0_q;
    assign pop = (state_q == FILL) & ~empty;
    assign ack = p_wb_ACK_I & stb_q;

    assign r_e         = pop;
    assign interrupt   = interrupt_q;
    assign p_wb_STB_O  = stb_q;
    assign p_wb_CYC_O  = cyc_q;
    assign p_wb_LOCK_O = 1'b0;
    assign p_wb_SEL_O  = 4'hF;
    assign p_wb_WE_O   = 1'b1;
    // Bus address/data only driven while a word is being offered.
    assign p_wb_ADR_O  = stb_q ? base_q + {13'd0, word_cnt_q, 2'b00} : '0;
    assign p_wb_DAT_O  = stb_q ? word : '0;

    pixel_packer #(
        .NBPACK (NBPACK)
    ) u_packer (
        .clk       (clk),
        .rst       (RST),
        .push      (pop),
        .pixel     (pixel_in),
        .pop_word  (ack),
        .last_byte (last_byte),
        .last_word (last_word),
        .word      (word)
    );

`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
    logic [15:0] frame_count_q;
    assign frame_count = frame_count_q;
`endif

    always_ff @(posedge clk) begin
        // Sampled through reset so a level held across reset does not arm.
        ctr0_q <= wb_reg_ctr[0];
        if (RST) begin
            state_q     <= IDLE;
            base_q      <= '0;
            word_cnt_q  <= '0;
            int_cnt_q   <= '0;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
            interrupt_q <= 1'b0;
`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
            frame_count_q <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    base_q <= {wb_reg_data[31:2], 2'b00};
                    if (arm) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (pop && last_byte) begin
                        state_q <= WRITE;
                        stb_q   <= 1'b1;
                        cyc_q   <= 1'b1;
                    end
                end
                WRITE: begin
                    if (ack) begin
                        word_cnt_q <= word_cnt_q + 17'd1;
                        if (last_word) begin
                            stb_q   <= 1'b0;
                            cyc_q   <= 1'b0;
                            state_q <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (word_cnt_q == 17'(FrameWords)) begin
                        state_q     <= DONE;
                        interrupt_q <= 1'b1;
                        int_cnt_q   <= '0;
`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
                        frame_count_q <= frame_count_q + 16'd1;
`endif
                    end else begin
                        state_q <= FILL;
                    end
                end
                DONE: begin
                    int_cnt_q <= int_cnt_q + 2'd1;
                    if (int_cnt_q == 2'd3) begin
                        state_q     <= IDLE;
                        interrupt_q <= 1'b0;
                        word_cnt_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_in_write.sv
// Directed bench for video_in_write with a small 16x8 frame (two 16-word bursts per frame).
module tb_video_in_write;

    localparam logic [31:0] Base = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] wb_reg_data = 32'h1000_0003;
    logic [31:0] wb_reg_ctr = 32'd0;
    logic        interrupt;
    logic [31:0] p_wb_DAT_O;
    logic        wb_ack = 1'b0;
    logic        p_wb_STB_O;
    logic        p_wb_CYC_O;
    logic        p_wb_LOCK_O;
    logic [3:0]  p_wb_SEL_O;
    logic        p_wb_WE_O;
    logic [31:0] p_wb_ADR_O;
    logic        empty = 1'b0;
    logic        r_e;
    logic [7:0]  pixel_in = 8'h01;
`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    video_in_write #(
        .NBPACK   (16),
        .p_WIDTH  (16),
        .p_HEIGHT (8)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .wb_reg_data (wb_reg_data),
        .wb_reg_ctr  (wb_reg_ctr),
        .interrupt   (interrupt),
        .p_wb_DAT_O  (p_wb_DAT_O),
        .p_wb_ACK_I  (wb_ack),
        .p_wb_STB_O  (p_wb_STB_O),
        .p_wb_CYC_O  (p_wb_CYC_O),
        .p_wb_LOCK_O (p_wb_LOCK_O),
        .p_wb_SEL_O  (p_wb_SEL_O),
        .p_wb_WE_O   (p_wb_WE_O),
        .p_wb_ADR_O  (p_wb_ADR_O),
        .empty       (empty),
        .r_e         (r_e),
`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
        .frame_count (frame_count),
`endif
        .pixel_in    (pixel_in)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          ack_delay = 0;
    bit          empty_mode = 1'b0;
    logic [7:0]  pix_val = 8'h01;
    logic        pop_pend = 1'b0;
    logic        ack_pend = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] adr_s, dat_s, adr_prev, dat_prev;
    logic        stb_prev = 1'b0;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    int          pop_cnt = 0;
    int          pop64_cyc = 0;
    int          first_stb_cyc = 0;
    bit          first_stb_seen = 1'b0;
    int          stb_cycles = 0;
    int          unstable = 0;
    int          re_bad = 0;
    int          int_run = 0;
    int          int_len = 0;
    int          irq_cnt = 0;

    // FIFO and Wishbone slave model; everything updated on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (pop_pend) begin
                pix_val++;
                pop_cnt++;
                if (pop_cnt == 64) pop64_cyc = cyc_n;
            end
            if (ack_pend) begin
                log_adr.push_back(adr_s);
                log_dat.push_back(dat_s);
                wait_cnt = 0;
            end
            if (p_wb_STB_O) begin
                stb_cycles++;
                if (!first_stb_seen) begin
                    first_stb_seen = 1'b1;
                    first_stb_cyc  = cyc_n;
                end
                if (stb_prev && !ack_pend && (p_wb_ADR_O !== adr_prev || p_wb_DAT_O !== dat_prev))
                    unstable++;
                if (wait_cnt >= ack_delay) begin
                    wb_ack = 1'b1;
                end else begin
                    wb_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                wb_ack   = 1'b0;
                wait_cnt = 0;
            end
            ack_pend = wb_ack && p_wb_STB_O;
            adr_s    = p_wb_ADR_O;
            dat_s    = p_wb_DAT_O;
            adr_prev = p_wb_ADR_O;
            dat_prev = p_wb_DAT_O;
            stb_prev = p_wb_STB_O;
            if (interrupt) begin
                int_run++;
            end else if (int_run != 0) begin
                int_len = int_run;
                int_run = 0;
                irq_cnt++;
            end
            empty    = empty_mode ? ~empty : 1'b0;
            pixel_in = pix_val;
            #1;
            if (r_e && empty) re_bad++;
            pop_pend = r_e && !empty;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic arm();
        wb_reg_ctr = 32'd0;
        step(2);
        wb_reg_ctr = 32'd1;
        step(1);
    endtask

    task automatic clear_logs();
        log_adr.delete();
        log_dat.delete();
        pop_cnt        = 0;
        stb_cycles     = 0;
        unstable       = 0;
        re_bad         = 0;
        first_stb_seen = 1'b0;
    endtask

    task automatic wait_irq(input string tag, input int budget);
        int start = irq_cnt;
        int n = 0;
        while (irq_cnt == start && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_irq"}, 32'(irq_cnt - start), 32'd1);
    endtask

    function automatic logic [31:0] adr_at(input int i);
        return (i < log_adr.size()) ? log_adr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] dat_at(input int i);
        return (i < log_dat.size()) ? log_dat[i] : 32'hFFFF_FFFF;
    endfunction

    // Expect 32 words at consecutive addresses carrying a consecutive pixel stream from p0.
    task automatic check_frame(input string tag, input logic [7:0] p0);
        int          bad = 0;
        logic [7:0]  p;
        logic [31:0] ew;
        chk({tag, "_words"}, 32'(log_adr.size()), 32'd32);
        foreach (log_adr[k]) begin
            p  = p0 + 8'(4 * k);
            ew = {p, p + 8'd1, p + 8'd2, p + 8'd3};
            if (log_adr[k] !== Base + 32'(4 * k) || log_dat[k] !== ew) bad++;
        end
        chk({tag, "_stream"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int start;
        int n;
        step(3);
        chk("reset_stb", 32'(p_wb_STB_O), 32'd0);
        chk("reset_cyc", 32'(p_wb_CYC_O), 32'd0);
        chk("reset_re", 32'(r_e), 32'd0);
        chk("reset_irq", 32'(interrupt), 32'd0);
        chk("reset_adr", p_wb_ADR_O, 32'd0);
        chk("reset_dat", p_wb_DAT_O, 32'd0);
        chk("const_lock", 32'(p_wb_LOCK_O), 32'd0);
        chk("const_sel", 32'(p_wb_SEL_O), 32'hF);
        chk("const_we", 32'(p_wb_WE_O), 32'd1);
`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
        chk("reset_frame_count", 32'(frame_count), 32'd0);
`endif
        RST = 1'b0;
        step(2);

        // T1/T2: full frame, FIFO never empty, immediate ACK.
        clear_logs();
        arm();
        wait_irq("t1", 2000);
        check_frame("t1", 8'h01);
        chk("t1_adr_first", adr_at(0), 32'h1000_0000);
        chk("t1_adr_last", adr_at(31), 32'h1000_007C);
        chk("t2_dat_first", dat_at(0), 32'h0102_0304);
        chk("t1_irq_len", 32'(int_len), 32'd4);
        chk("t1_stb_latency", 32'(first_stb_cyc - pop64_cyc), 32'd0);
        chk("t1_pops", 32'(pop_cnt), 32'd128);
`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
        chk("t1_frame_count", 32'(frame_count), 32'd1);
`endif

        // T3 with a T6 arm edge during FILL.
        clear_logs();
        ack_delay = 3;
        arm();
        step(20);
        wb_reg_ctr = 32'd0;
        step(2);
        wb_reg_ctr = 32'd1;
        wait_irq("t3", 3000);
        check_frame("t3", 8'h81);
        chk("t3_unstable", 32'(unstable), 32'd0);
        chk("t3_stb_cycles", 32'(stb_cycles), 32'd128);
        start = irq_cnt;
        step(150);
        chk("t6_no_rearm_words", 32'(log_adr.size()), 32'd32);
        chk("t6_no_rearm_irq", 32'(irq_cnt - start), 32'd0);

        // T4: FIFO empty every other cycle.
        clear_logs();
        ack_delay  = 0;
        empty_mode = 1'b1;
        arm();
        wait_irq("t4", 3000);
        check_frame("t4", 8'h01);
        chk("t4_re_when_empty", 32'(re_bad), 32'd0);
        chk("t4_pops", 32'(pop_cnt), 32'd128);
        empty_mode = 1'b0;
`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
        chk("t4_frame_count", 32'(frame_count), 32'd3);
`endif

        // T5: reset while word 5 is on the bus.
        clear_logs();
        arm();
        n = 0;
        while (log_adr.size() < 5 && n < 2000) begin
            step(1);
            n++;
        end
        chk("t5_reach_word5", 32'(log_adr.size()), 32'd5);
        RST = 1'b1;
        step(1);
        chk("t5_stb", 32'(p_wb_STB_O), 32'd0);
        chk("t5_cyc", 32'(p_wb_CYC_O), 32'd0);
        step(1);
        RST = 1'b0;
        step(3);
        clear_logs();
        step(20);
        chk("t5_idle_words", 32'(log_adr.size()), 32'd0);
        chk("t5_idle_re", 32'(r_e), 32'd0);
`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
        chk("t5_frame_count", 32'(frame_count), 32'd0);
`endif
        arm();
        wait_irq("t5b", 2000);
        check_frame("t5b", 8'hC1);
        chk("t5b_adr_first", adr_at(0), 32'h1000_0000);

        // T6: second full frame after the reset.
        clear_logs();
        arm();
        wait_irq("t6", 2000);
        check_frame("t6", 8'h41);
`ifdef VIDEO_IN_WRITE_FRAME_CNT_EN
        chk("t6_frame_count", 32'(frame_count), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
